// File: rtl/short_sequencer_if.sv
// Host/config side and array side of the short sequencer, bundled for one modport connection.
// master drives start/abort/config and observes status; slave is the sequencer itself.
interface short_sequencer_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [N-1:0]     short_mask;
  logic [CNT_W-1:0] short_cycles;
  logic [CNT_W-1:0] run_cycles;
  logic [N-1:0]     short_en;
  logic             sample;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, short_mask, short_cycles, run_cycles,
    input  short_en, sample, busy, done
  );

  modport slave (
    input  start, abort, short_mask, short_cycles, run_cycles,
    output short_en, sample, busy, done
  );
endinterface

// File: rtl/short_sequencer.sv
// Anneal sequencer: SHORT (mask held) -> RUN -> SAMPLE strobe -> DONE; outputs registered from next state.
// No backpressure: start is taken only in IDLE, abort preempts; SHORT_ANNEAL_EN repeats SHORT/RUN for ROUNDS rounds.
module short_sequencer #(
  parameter int N      = 8,
  parameter int CNT_W  = 16,
  parameter int ROUNDS = 4
) (
  input logic              clk,
  input logic              rst,
  short_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHORT  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    state_t           st;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  // First non-empty phase of a round; the counter holds (length-1) so it ends on 0.
  function automatic entry_t f_enter(input logic [CNT_W-1:0] s_len,
                                     input logic [CNT_W-1:0] r_len);
    entry_t e;
    e.st  = ST_SAMPLE;
    e.cnt = '0;
    if (s_len != '0) begin
      e.st  = ST_SHORT;
      e.cnt = s_len - 1'b1;
    end else if (r_len != '0) begin
      e.st  = ST_RUN;
      e.cnt = r_len - 1'b1;
    end
    return e;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_mask;
  logic [CNT_W-1:0] r_run_cycles;
  logic [N-1:0]     r_short_en;
  logic             r_sample;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  entry_t           w_entry;
  entry_t           w_round_end;
  logic [N-1:0]     w_mask_src;
  logic [N-1:0]     w_short_en_nxt;
  logic             w_sample_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

`ifdef SHORT_ANNEAL_EN
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  logic [CNT_W-1:0] r_short_cycles;
  logic [RW-1:0]    r_round;
  logic [RW-1:0]    w_round_nxt;
  logic [RW:0]      w_round_p1;
  logic             w_last_round;
`endif

  assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.abort;

  // Next state / counter / round
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_entry     = f_enter(bus.short_cycles, bus.run_cycles);
`ifdef SHORT_ANNEAL_EN
    w_round_nxt  = r_round;
    w_round_p1   = {1'b0, r_round} + 1'b1;
    w_last_round = (r_round == RW'(ROUNDS - 1));
    if (w_last_round) begin
      w_round_end.st  = ST_SAMPLE;
      w_round_end.cnt = '0;
    end else begin
      w_round_end = f_enter(r_short_cycles >> w_round_p1, r_run_cycles);
    end
`else
    w_round_end.st  = ST_SAMPLE;
    w_round_end.cnt = '0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_entry.st;
          w_cnt_nxt   = w_entry.cnt;
`ifdef SHORT_ANNEAL_EN
          w_round_nxt = '0;
`endif
        end
      end
      ST_SHORT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (r_run_cycles != '0) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = r_run_cycles - 1'b1;
        end else begin
          w_state_nxt = w_round_end.st;
          w_cnt_nxt   = w_round_end.cnt;
`ifdef SHORT_ANNEAL_EN
          if (!w_last_round) w_round_nxt = w_round_p1[RW-1:0];
`endif
        end
      end
      ST_RUN: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = w_round_end.st;
          w_cnt_nxt   = w_round_end.cnt;
`ifdef SHORT_ANNEAL_EN
          if (!w_last_round) w_round_nxt = w_round_p1[RW-1:0];
`endif
        end
      end
      ST_SAMPLE: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase

    if (bus.abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
`ifdef SHORT_ANNEAL_EN
      w_round_nxt = '0;
`endif
    end
  end

  // Output decode from next state; mask comes straight from the input on the start cycle.
  always_comb begin
    w_mask_src     = (r_state == ST_IDLE) ? bus.short_mask : r_mask;
    w_short_en_nxt = (w_state_nxt == ST_SHORT) ? w_mask_src : '0;
    w_sample_nxt   = (w_state_nxt == ST_SAMPLE);
    w_busy_nxt     = (w_state_nxt == ST_SHORT) || (w_state_nxt == ST_RUN) ||
                     (w_state_nxt == ST_SAMPLE);
    w_done_nxt     = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_run_cycles <= '0;
      r_short_en   <= '0;
      r_sample     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef SHORT_ANNEAL_EN
      r_short_cycles <= '0;
      r_round        <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_short_en <= w_short_en_nxt;
      r_sample   <= w_sample_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
`ifdef SHORT_ANNEAL_EN
      r_round <= w_round_nxt;
`endif
      if (w_accept) begin
        r_mask       <= bus.short_mask;
        r_run_cycles <= bus.run_cycles;
`ifdef SHORT_ANNEAL_EN
        r_short_cycles <= bus.short_cycles;
`endif
      end
    end
  end

  assign bus.short_en = r_short_en;
  assign bus.sample   = r_sample;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_short_sequencer.sv
// Directed bench for short_sequencer: vector table plus generated expectations for long sequences.
module tb_short_sequencer;
  localparam int N      = 8;
  localparam int CNT_W  = 16;
  localparam int ROUNDS = 4;
`ifdef SHORT_ANNEAL_EN
  localparam int NR = ROUNDS;
`else
  localparam int NR = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  short_sequencer_if #(.N(N), .CNT_W(CNT_W)) sif ();

  short_sequencer #(.N(N), .CNT_W(CNT_W), .ROUNDS(ROUNDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  mask;
    logic [15:0] sc;
    logic [15:0] rc;
    logic [10:0] exp;   // {short_en, sample, busy, done}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic st, input logic ab, input logic [7:0] m,
                     input logic [15:0] sc, input logic [15:0] rc,
                     input logic [7:0] en, input logic smp, input logic bsy, input logic dn);
    vec_t v;
    v.rst = r; v.start = st; v.abort = ab; v.mask = m; v.sc = sc; v.rc = rc;
    v.exp = {en, smp, bsy, dn};
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then check the registered outputs just after the edge.
  task automatic step(input logic r, input logic st, input logic ab, input logic [7:0] m,
                      input logic [15:0] sc, input logic [15:0] rc,
                      input logic [10:0] exp, input string tag);
    logic [10:0] act;
    @(negedge clk);
    rst = r; sif.start = st; sif.abort = ab;
    sif.short_mask = m; sif.short_cycles = sc; sif.run_cycles = rc;
    @(posedge clk);
    #1;
    act = {sif.short_en, sif.sample, sif.busy, sif.done};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got en=%h sample=%b busy=%b done=%b, want en=%h sample=%b busy=%b done=%b",
               tag, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Expected trace built round by round: SHORT bursts of s>>r, RUN of r, then SAMPLE, DONE, IDLE.
  task automatic run_seq(input string nm, input logic [7:0] m,
                         input logic [15:0] s, input logic [15:0] r);
    logic [10:0] exp_q[$];
    for (int rd = 0; rd < NR; rd++) begin
      for (int c = 0; c < int'(s >> rd); c++) exp_q.push_back({m, 3'b010});
      for (int c = 0; c < int'(r); c++)       exp_q.push_back({8'h00, 3'b010});
    end
    exp_q.push_back({8'h00, 3'b110});
    exp_q.push_back({8'h00, 3'b001});
    exp_q.push_back({8'h00, 3'b000});
    exp_q.push_back({8'h00, 3'b000});
    foreach (exp_q[i])
      step(1'b0, (i == 0), 1'b0, m, s, r, exp_q[i], $sformatf("%s cyc%0d", nm, i + 1));
  endtask

  initial begin
    rst = 1'b1;
    sif.start = 1'b0; sif.abort = 1'b0;
    sif.short_mask = '0; sif.short_cycles = '0; sif.run_cycles = '0;

    step(1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 16'd0, 11'h000, "reset0");
    step(1'b1, 1'b1, 1'b0, 8'hFF, 16'd3, 16'd3, 11'h000, "reset1");

`ifndef SHORT_ANNEAL_EN
    // basic: mask A5, S=3, R=4
    add(0,1,0,8'hA5,3,4, 8'hA5,0,1,0);
    add(0,0,0,8'hA5,3,4, 8'hA5,0,1,0);
    add(0,0,0,8'hA5,3,4, 8'hA5,0,1,0);
    add(0,0,0,8'hA5,3,4, 8'h00,0,1,0);
    add(0,0,0,8'hA5,3,4, 8'h00,0,1,0);
    add(0,0,0,8'hA5,3,4, 8'h00,0,1,0);
    add(0,0,0,8'hA5,3,4, 8'h00,0,1,0);
    add(0,0,0,8'hA5,3,4, 8'h00,1,1,0);
    add(0,0,0,8'hA5,3,4, 8'h00,0,0,1);
    add(0,0,0,8'hA5,3,4, 8'h00,0,0,0);
    // zero lengths
    add(0,1,0,8'hFF,0,0, 8'h00,1,1,0);
    add(0,0,0,8'hFF,0,0, 8'h00,0,0,1);
    add(0,0,0,8'hFF,0,0, 8'h00,0,0,0);
    // mask change in SHORT and start in RUN are ignored
    add(0,1,0,8'hA5,3,2, 8'hA5,0,1,0);
    add(0,0,0,8'hFF,3,2, 8'hA5,0,1,0);
    add(0,0,0,8'hFF,3,2, 8'hA5,0,1,0);
    add(0,0,0,8'hFF,3,2, 8'h00,0,1,0);
    add(0,1,0,8'hFF,0,0, 8'h00,0,1,0);
    add(0,0,0,8'hFF,0,0, 8'h00,1,1,0);
    add(0,0,0,8'hFF,0,0, 8'h00,0,0,1);
    add(0,0,0,8'hFF,0,0, 8'h00,0,0,0);
    add(0,0,0,8'hFF,0,0, 8'h00,0,0,0);
    // abort in SHORT cycle 2, restart two cycles later
    add(0,1,0,8'hA5,5,3, 8'hA5,0,1,0);
    add(0,0,0,8'hA5,5,3, 8'hA5,0,1,0);
    add(0,0,1,8'hA5,5,3, 8'h00,0,0,0);
    add(0,0,0,8'hA5,5,3, 8'h00,0,0,0);
    add(0,1,0,8'h3C,1,1, 8'h3C,0,1,0);
    add(0,0,0,8'h3C,1,1, 8'h00,0,1,0);
    add(0,0,0,8'h3C,1,1, 8'h00,1,1,0);
    add(0,0,0,8'h3C,1,1, 8'h00,0,0,1);
    add(0,0,0,8'h3C,1,1, 8'h00,0,0,0);
    // start with abort in IDLE
    add(0,1,1,8'hFF,2,2, 8'h00,0,0,0);
    add(0,0,0,8'hFF,2,2, 8'h00,0,0,0);
    // rst during RUN, then a clean run
    add(0,1,0,8'h0F,1,3, 8'h0F,0,1,0);
    add(0,0,0,8'h0F,1,3, 8'h00,0,1,0);
    add(1,0,0,8'h0F,1,3, 8'h00,0,0,0);
    add(0,0,0,8'h0F,1,3, 8'h00,0,0,0);
    add(0,1,0,8'h00,0,1, 8'h00,0,1,0);
    add(0,0,0,8'h00,0,1, 8'h00,1,1,0);
    add(0,0,0,8'h00,0,1, 8'h00,0,0,1);
    add(0,0,0,8'h00,0,1, 8'h00,0,0,0);
    // all-zero mask still spends S cycles in SHORT
    add(0,1,0,8'h00,2,0, 8'h00,0,1,0);
    add(0,0,0,8'h00,2,0, 8'h00,0,1,0);
    add(0,0,0,8'h00,2,0, 8'h00,1,1,0);
    add(0,0,0,8'h00,2,0, 8'h00,0,0,1);
    add(0,0,0,8'h00,2,0, 8'h00,0,0,0);
    // abort in SAMPLE suppresses done; abort in DONE keeps it
    add(0,1,0,8'hFF,0,0, 8'h00,1,1,0);
    add(0,0,1,8'hFF,0,0, 8'h00,0,0,0);
    add(0,0,0,8'hFF,0,0, 8'h00,0,0,0);
    add(0,1,0,8'hFF,0,0, 8'h00,1,1,0);
    add(0,0,0,8'hFF,0,0, 8'h00,0,0,1);
    add(0,0,1,8'hFF,0,0, 8'h00,0,0,0);
    add(0,0,0,8'hFF,0,0, 8'h00,0,0,0);

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].start, vecs[i].abort, vecs[i].mask,
           vecs[i].sc, vecs[i].rc, vecs[i].exp, $sformatf("vec%0d", i));
`endif

    run_seq("seq_s8_r2", 8'hA5, 16'd8, 16'd2);
    run_seq("seq_s2_r2", 8'h5A, 16'd2, 16'd2);
    run_seq("seq_s3_r0", 8'hC3, 16'd3, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/short_sequencer.md
Name: short_sequencer

Overview:
- Sequences the shorted ring-oscillator cells of the Ising array through an anneal cycle.
- Holds a selected subset of shorted cells phase-locked for a programmed number of cycles, then releases them to free-run.
- Pulses a phase-sample strobe to the readout logic, then signals completion.
- Sits between the host/config register block and the array's per-cell short-enable inputs.

Parameters:
N, 8, number of shorted cells controlled (width of mask/enable vectors)
CNT_W, 16, width of the cycle-count inputs and the internal down-counter
ROUNDS, 4, anneal rounds when SHORT_ANNEAL_EN is defined; ignored otherwise

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a sequence; accepted only in IDLE
abort  input  1  terminate any sequence; returns to IDLE
short_mask  input  N  cells to short during SHORT; sampled on accepted start
short_cycles  input  CNT_W  SHORT phase length in clk cycles; sampled on accepted start
run_cycles  input  CNT_W  RUN phase length in clk cycles; sampled on accepted start
short_en  output  N  per-cell short enable to the array, registered
sample  output  1  one-cycle strobe: readout captures oscillator phases
busy  output  1  high in SHORT, RUN, SAMPLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: state=IDLE; short_en=0, sample=0, busy=0, done=0; counter=0; latched mask/counts=0. rst mid-sequence wins over all inputs; outputs at reset values the next cycle.
- All outputs are registered and decoded from state.
- States: IDLE, SHORT, RUN, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0 latches short_mask, short_cycles and run_cycles.
  - Next state is SHORT if short_cycles!=0; else RUN if run_cycles!=0; else SAMPLE.
  - The counter is loaded with (length-1) of the entered phase.
- SHORT:
  - short_en = latched mask for exactly short_cycles cycles; busy=1.
  - Counter decrements each cycle. At 0, go to RUN (loaded run_cycles-1), or to SAMPLE if run_cycles==0.
- RUN:
  - short_en=0, busy=1, for exactly run_cycles cycles.
  - At counter 0, go to SAMPLE.
- SAMPLE: sample=1, busy=1 for one cycle, then go to DONE.
- DONE: done=1, busy=0 for one cycle, then go to IDLE.
- Latency: start at cycle k. SHORT spans k+1..k+S, RUN spans k+S+1..k+S+R, sample at k+S+R+1, done at k+S+R+2. Next start is accepted at k+S+R+3.
- start outside IDLE is ignored; it is not queued.
- Changing the inputs mid-sequence has no effect, because only the latched copies are used.
- abort=1 in any state except IDLE: next state is IDLE with short_en=0, sample=0, done=0, busy=0. No sample or done is emitted for the aborted sequence.
- abort and start together in IDLE: abort wins and the start is dropped.
- abort in DONE: done is still emitted that cycle (already registered); state goes to IDLE.
- The counter never wraps: it is only decremented when nonzero and always reloaded on phase entry.
- A short_mask of all zeros is legal: SHORT still lasts short_cycles with short_en=0.

Optional Feature:
SHORT_ANNEAL_EN
- Defined:
  - The SHORT→RUN pair repeats ROUNDS times, with round index r=0..ROUNDS-1.
  - Round r's SHORT length is short_cycles>>r. A computed length of 0 skips that round's SHORT.
  - RUN length is run_cycles every round.
  - SAMPLE and DONE occur once, after the final RUN.
  - Round index resets to 0 on start, abort and rst.
  - abort behaves identically in any round.
- Undefined: single round exactly as in Behaviour; ROUNDS is unused and no round logic is synthesized.

Test Plan:
- Basic: rst 2 cycles, then mask=8'hA5, short_cycles=3, run_cycles=4, start at cycle k.
  - short_en=8'hA5 on k+1..k+3 and 0 afterwards.
  - busy on k+1..k+8; sample at k+8; done at k+9.
- Zero lengths: short_cycles=0, run_cycles=0 → short_en never set; sample at k+1; done at k+2.
- Ignored start/input change: start pulsed during RUN, and short_mask changed to 8'hFF during SHORT → single sample/done pair only; short_en stays 8'hA5 throughout SHORT.
- Abort: abort at SHORT cycle 2 with short_cycles=5 → short_en=0, busy=0 next cycle; no sample/done ever; a new start 2 cycles later runs normally.
- Simultaneous: start=1 and abort=1 in IDLE → stays IDLE, no outputs. Also rst asserted in RUN → all outputs 0 next cycle.
- SHORT_ANNEAL_EN, ROUNDS=4, short_cycles=8, run_cycles=2:
  - short_en bursts of 8, 4, 2, 1 cycles, each followed by 2 RUN cycles.
  - Exactly one sample at k+24.
  - Repeat with short_cycles=2 → rounds 2 and 3 skip SHORT, giving sample at k+12.
